sid_filter_output_stage: RTL and testbench

SID_FILTER_OUTPUT_STAGE -- requirements
Module: sid_filter_output_stage

---
 rtl/sid_filter_output_stage.sv | 110 +++++++++++
 tb/tb_sid_filter_output_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_filter_output_stage.sv
// SID filter back end: 17->16 bit clipper, state-variable filter, 15 kHz output low-pass.
// Clipper is combinational; filter/output state updates on clkEn, visible next cycle; no backpressure.
module sid_filter_output_stage (
  input  logic               clk,
  input  logic               iRstN,
  input  logic               clkEn,
  input  logic               iWE,
  input  logic [4:0]         iAddr,
  input  logic [7:0]         iData,
  input  logic               i6581,
  input  logic signed [15:0] iIn,
  input  logic signed [16:0] iMix,
  input  logic signed [15:0] iPost,
  output logic signed [15:0] oLP,
  output logic signed [15:0] oBP,
  output logic signed [15:0] oHP,
  output logic signed [15:0] oClip,
  output logic signed [15:0] oOut
);

  logic [10:0]        fc;
  logic [3:0]         res;
  logic signed [15:0] lp, bp, hp;
  logic signed [31:0] acc;

  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    if (v[33:15] == {19{v[33]}}) return v[15:0];
    return v[33] ? 16'sh8000 : 16'sh7fff;
  endfunction

  // Cutoff and damping coefficients follow the register file combinationally,
  // so a write takes effect on the first clkEn update after it lands.
  logic [13:0] fc_x5;
  logic [12:0] f;
  logic [8:0]  d;

  assign fc_x5 = ({3'b000, fc} + 14'd1) * 14'd5;
  assign f     = 13'(fc_x5 >> 1) + (i6581 ? 13'd327 : 13'd0);
  assign d     = 9'd362 - ({5'b00000, res} * 9'd14);

  logic signed [33:0] f_s, d_s, bp_x, lp_x, in_x, lp_nx_x, hp_nx_x;
  logic signed [33:0] p_fb, p_db, p_fh, lp_sum, hp_sum, bp_sum;
  logic signed [15:0] lp_nx, hp_nx, bp_nx;

  always_comb begin
    f_s     = $signed({21'd0, f});
    d_s     = $signed({25'd0, d});
    bp_x    = {{18{bp[15]}}, bp};
    lp_x    = {{18{lp[15]}}, lp};
    in_x    = {{18{iIn[15]}}, iIn};
    p_fb    = f_s * bp_x;
    lp_sum  = lp_x + (p_fb >>> 16);
    lp_nx   = sat16(lp_sum);
    lp_nx_x = {{18{lp_nx[15]}}, lp_nx};
    p_db    = d_s * bp_x;
    hp_sum  = in_x - lp_nx_x - (p_db >>> 8);
    hp_nx   = sat16(hp_sum);
    hp_nx_x = {{18{hp_nx[15]}}, hp_nx};
    p_fh    = f_s * hp_nx_x;
    bp_sum  = bp_x + (p_fh >>> 16);
    bp_nx   = sat16(bp_sum);
  end

  // One-pole output stage in Q16.16; the error term needs 33 bits before the multiply.
  logic signed [47:0] post_q, acc_x, err, step;
  logic signed [31:0] acc_nx;

  always_comb begin
    post_q = {{16{iPost[15]}}, iPost, 16'd0};
    acc_x  = {{16{acc[31]}}, acc};
    err    = post_q - acc_x;
    step   = (err * 48'sd6176) >>> 16;
    acc_nx = acc + 32'(step);
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      fc  <= '0;
      res <= '0;
    end else if (iWE) begin
      case (iAddr)
        5'h15:   fc[2:0]  <= iData[2:0];
        5'h16:   fc[10:3] <= iData;
        5'h17:   res      <= iData[7:4];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      lp  <= '0;
      bp  <= '0;
      hp  <= '0;
      acc <= '0;
    end else if (clkEn) begin
      lp  <= lp_nx;
      bp  <= bp_nx;
      hp  <= hp_nx;
      acc <= acc_nx;
    end
  end

  assign oLP   = lp;
  assign oBP   = bp;
  assign oHP   = hp;
  assign oOut  = acc[31:16];
  assign oClip = sat16({{17{iMix[16]}}, iMix});

endmodule

// File: tb/tb_sid_filter_output_stage.sv
// Self-checking bench for sid_filter_output_stage: vector tables, corner sequences,
// and randomized traffic against an integer reference model.
module tb_sid_filter_output_stage;

  logic               clk = 1'b0;
  logic               iRstN, clkEn, iWE, i6581;
  logic [4:0]         iAddr;
  logic [7:0]         iData;
  logic signed [15:0] iIn, iPost;
  logic signed [16:0] iMix;
  logic signed [15:0] oLP, oBP, oHP, oClip, oOut;

  sid_filter_output_stage dut (
    .clk(clk), .iRstN(iRstN), .clkEn(clkEn), .iWE(iWE), .iAddr(iAddr), .iData(iData),
    .i6581(i6581), .iIn(iIn), .iMix(iMix), .iPost(iPost),
    .oLP(oLP), .oBP(oBP), .oHP(oHP), .oClip(oClip), .oOut(oOut)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  longint m_lp, m_bp, m_hp, m_acc;
  int     m_fc, m_res;

  typedef struct { logic signed [16:0] mix; int exp; } clip_t;
  typedef struct { int v6581; int fc; int res; int in; int lp; int hp; int bp; } upd_t;

  clip_t ctab[10];
  upd_t  utab[5];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Floor division by 2**sh, i.e. what an arithmetic right shift means numerically.
  function automatic longint fdiv(input longint a, input int sh);
    longint p;
    p = longint'(1) << sh;
    if (a >= 0) return a / p;
    return -((-a + p - 1) / p);
  endfunction

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_zero();
    m_lp = 0; m_bp = 0; m_hp = 0; m_acc = 0; m_fc = 0; m_res = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    longint f, d;
    if (!iRstN) begin
      model_zero();
      return;
    end
    if (clkEn) begin
      f = longint'((m_fc + 1) * 5 / 2) + (i6581 ? 327 : 0);
      d = 362 - 14 * m_res;
      m_lp  = sat(m_lp + fdiv(f * m_bp, 16));
      m_hp  = sat(longint'(iIn) - m_lp - fdiv(d * m_bp, 8));
      m_bp  = sat(m_bp + fdiv(f * m_hp, 16));
      m_acc = m_acc + fdiv((longint'(iPost) * 65536 - m_acc) * 6176, 16);
    end
    if (iWE) begin
      case (iAddr)
        5'h15:   m_fc = (m_fc & 'h7F8) | (iData & 7);
        5'h16:   m_fc = (m_fc & 7) | (int'(iData) << 3);
        5'h17:   m_res = iData >> 4;
        default: ;
      endcase
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".lp"},  oLP,  m_lp);
    chk({tag, ".bp"},  oBP,  m_bp);
    chk({tag, ".hp"},  oHP,  m_hp);
    chk({tag, ".out"}, oOut, fdiv(m_acc, 16));
  endtask

  // Inputs are set 1 ns after a rising edge; outputs are read 1 ns after the next one.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] v);
    iWE = 1'b1; iAddr = a; iData = v;
    cyc();
    iWE = 1'b0;
  endtask

  task automatic reset_dut();
    iRstN = 1'b0; clkEn = 1'b0; iWE = 1'b0;
    #1;
    model_zero();
    @(posedge clk);
    #1;
    iRstN = 1'b1;
  endtask

  longint snap_lp, snap_bp, snap_hp, snap_out;

  initial begin
    ctab[0] = '{17'sd40000, 32767};
    ctab[1] = '{-17'sd40000, -32768};
    ctab[2] = '{17'sd1234, 1234};
    ctab[3] = '{17'sd32767, 32767};
    ctab[4] = '{17'sd32768, 32767};
    ctab[5] = '{-17'sd32768, -32768};
    ctab[6] = '{-17'sd32769, -32768};
    ctab[7] = '{17'sd0, 0};
    ctab[8] = '{17'sd65535, 32767};
    ctab[9] = '{-17'sd65536, -32768};
    //          6581  fc    res  in      lp  hp      bp
    utab[0] = '{0,    0,    0,   16384,  0,  16384,  0};
    utab[1] = '{1,    0,    0,   16384,  0,  16384,  82};
    utab[2] = '{0,    2047, 0,   16384,  0,  16384,  1280};
    utab[3] = '{1,    2047, 0,   -32768, 0,  -32768, -2724};
    utab[4] = '{0,    5,    15,  -100,   0,  -100,   -1};

    iRstN = 1'b0; clkEn = 1'b0; iWE = 1'b0; iAddr = '0; iData = '0;
    i6581 = 1'b0; iIn = '0; iMix = '0; iPost = '0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    model_check("reset");

    // Clipper stays live while reset is held, and after release.
    for (int i = 0; i < 10; i++) begin
      iMix = ctab[i].mix; #1;
      chk("clip.in_reset", oClip, ctab[i].exp);
    end
    iRstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iMix = ctab[i].mix; #1;
      chk("clip", oClip, ctab[i].exp);
    end
    @(posedge clk);
    #1;

    // First update from the zero state for several coefficient settings.
    for (int i = 0; i < 5; i++) begin
      reset_dut();
      wr(5'h15, 8'(utab[i].fc & 7));
      wr(5'h16, 8'(utab[i].fc >> 3));
      wr(5'h17, 8'(utab[i].res << 4));
      i6581 = utab[i].v6581[0];
      iIn   = 16'(utab[i].in);
      clkEn = 1'b1;
      cyc();
      clkEn = 1'b0;
      chk("first.lp", oLP, utab[i].lp);
      chk("first.hp", oHP, utab[i].hp);
      chk("first.bp", oBP, utab[i].bp);
      chk("first.out", oOut, 0);
    end

    // A cutoff write on an update edge only affects the following update.
    reset_dut();
    i6581 = 1'b0; iIn = 16'sd16384; clkEn = 1'b1;
    wr(5'h16, 8'hFF);
    chk("fchg.bp_old_f", oBP, 0);
    cyc();
    clkEn = 1'b0;
    chk("fchg.bp_new_f", oBP, 1275);
    chk("fchg.hp", oHP, 16384);

    // Full-scale swing: hp must clamp rather than wrap.
    reset_dut();
    wr(5'h15, 8'h07);
    wr(5'h16, 8'hFF);
    i6581 = 1'b1; clkEn = 1'b1;
    iIn = -16'sd32768; cyc();
    iIn = 16'sd32767;  cyc();
    clkEn = 1'b0;
    chk("sat.lp", oLP, -227);
    chk("sat.hp", oHP, 32767);
    chk("sat.bp", oBP, -1);

    // Output stage step response.
    reset_dut();
    iPost = 16'sd10000; iIn = '0; i6581 = 1'b0; clkEn = 1'b1;
    cyc();
    chk("post.first", oOut, 942);
    repeat (299) cyc();
    chk_rng("post.settle", oOut, 9998, 10002);
    model_check("post");
    clkEn = 1'b0;

    // DC settling at maximum cutoff.
    reset_dut();
    wr(5'h15, 8'h07);
    wr(5'h16, 8'hFF);
    wr(5'h17, 8'h00);
    i6581 = 1'b0; iIn = 16'sd8192; iPost = 16'sd5000; clkEn = 1'b1;
    repeat (3000) cyc();
    clkEn = 1'b0;
    model_check("dc");
    // Truncating shifts leave a small dead band around the ideal settling point.
    chk_rng("dc.lp_band", oLP, 8192 - 32, 8192 + 32);
    chk_rng("dc.bp_band", oBP, -16, 16);
    chk_rng("dc.hp_band", oHP, -16, 16);

    // Hold: no state moves without clkEn even as the inputs toggle.
    snap_lp = m_lp; snap_bp = m_bp; snap_hp = m_hp; snap_out = fdiv(m_acc, 16);
    for (int i = 0; i < 100; i++) begin
      iIn   = (i % 2 == 1) ? 16'sd32767 : -16'sd32768;
      iPost = (i % 2 == 1) ? -16'sd32768 : 16'sd32767;
      cyc();
      if (i % 25 == 24) begin
        chk("hold.lp", oLP, snap_lp);
        chk("hold.bp", oBP, snap_bp);
        chk("hold.hp", oHP, snap_hp);
        chk("hold.out", oOut, snap_out);
      end
    end

    // Asynchronous reset between clock edges.
    #2;
    iRstN = 1'b0;
    #1;
    chk("arst.lp", oLP, 0);
    chk("arst.bp", oBP, 0);
    chk("arst.hp", oHP, 0);
    chk("arst.out", oOut, 0);
    iMix = -17'sd40000; #1;
    chk("arst.clip", oClip, -32768);
    model_zero();
    @(posedge clk);
    #1;
    iRstN = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      clkEn = ($urandom_range(0, 3) != 0);
      iWE   = ($urandom_range(0, 5) == 0);
      iAddr = 5'(20 + $urandom_range(0, 4));
      iData = 8'($urandom);
      if ($urandom_range(0, 63) == 0) i6581 = ~i6581;
      if ($urandom_range(0, 3) == 0) iIn = 16'($urandom);
      else iIn = 16'(int'($urandom_range(0, 8000)) - 4000);
      iPost = 16'($urandom);
      iMix  = 17'($urandom);
      cyc();
      model_check("rand");
      chk("rand.clip", oClip, sat(longint'(iMix)));
      if (i == 1000) begin
        #2;
        iRstN = 1'b0;
        #1;
        model_zero();
        model_check("rand.rst");
        iRstN = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
